// File: rtl/piso_dac_serializer_pkg.sv
// Shared serial-link definitions: FSM encoding reused by the PISO and SIPO sides.
// Optional parity bit is enabled by defining PISO_PARITY_EN.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } piso_state_e;

`ifdef PISO_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif

endpackage

// File: rtl/piso_dac_serializer_if.sv
// Parallel-load / serial-out bus between a frame source and the serializer.
// Master drives the word and ticks; slave returns serial data and status.
interface piso_dac_serializer_if #(
    parameter int N = 7
);
    logic [N:0] PDATA;
    logic       load;
    logic       SO_en;
    logic       SO;
    logic       cs_n;
    logic       busy;
    logic       eoc;

    modport master (
        output PDATA, load, SO_en,
        input  SO, cs_n, busy, eoc
    );

    modport slave (
        input  PDATA, load, SO_en,
        output SO, cs_n, busy, eoc
    );
endinterface

// File: rtl/piso_dac_serializer_bit_counter.sv
// Frame bit counter: loadable, decrements on enable, saturates at zero.
// last_o flags that the current bit is the final one of the frame.
module piso_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise decrement but never below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign last_o = (cnt_q == W'(1));
endmodule

// File: rtl/piso_dac_serializer.sv
// MSB-first parallel-in/serial-out DAC frame serializer with cs_n framing.
// Define PISO_PARITY_EN to append an even-parity bit after the data LSB.
module piso_dac_serializer
    import serial_pkg::*;
#(
    parameter int   N       = 7,
    parameter logic IDLE_SO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_dac_serializer_if.slave bus
);
    localparam int LEN = N + 1 + int'(PAR_BITS);
    localparam int CW  = $clog2(N + 3);

    piso_state_e    state_q, state_d;
    logic [LEN-1:0] sr_q, sr_d;
    logic [LEN-1:0] cap;
    logic           cnt_load;
    logic           cnt_en;
    logic           cnt_zero;
    logic           cnt_last;
    logic           so_d;
    logic           cs_n_d;
    logic           busy_d;
    logic           eoc_d;

`ifdef PISO_PARITY_EN
    assign cap = {bus.PDATA, ^bus.PDATA};
`else
    assign cap = bus.PDATA;
`endif

    piso_bit_counter #(
        .W(CW)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(CW'(LEN)),
        .en_i      (cnt_en),
        .zero_o    (cnt_zero),
        .last_o    (cnt_last)
    );

    // Next-state, shift-register update and frame outputs.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        so_d     = IDLE_SO;
        cs_n_d   = 1'b1;
        busy_d   = 1'b0;
        eoc_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sr_d     = cap;
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                cs_n_d = 1'b0;
                busy_d = 1'b1;
                so_d   = sr_q[LEN-1];
                if (bus.SO_en) begin
                    sr_d   = {sr_q[LEN-2:0], 1'b0};
                    cnt_en = 1'b1;
                    if (cnt_last || cnt_zero) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b1;
                eoc_d   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and shift register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
        end
    end

    assign bus.SO   = so_d;
    assign bus.cs_n = cs_n_d;
    assign bus.busy = busy_d;
    assign bus.eoc  = eoc_d;
endmodule
